// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared definitions for the systolic feed controller: state encoding,
// default array geometry and the lane-packing helper.
package systolic_pkg;

  localparam int DEF_ARRAY_DIM = 4;
  localparam int DEF_K_DEPTH   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // LSB position of lane `lane` inside a packed multi-lane bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Control, scratchpad-read and array-feed signals of the systolic feed controller.
interface systolic_feed_ctrl_if
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ARRAY_DIM  = DEF_ARRAY_DIM,
  parameter int ADDR_WIDTH = 5
);
  logic                            start;
  logic                            abort;
  logic [ADDR_WIDTH-1:0]           base_addr;
  logic                            busy;
  logic                            done;
  logic                            sp_rd_en;
  logic [ADDR_WIDTH-1:0]           sp_rd_addr;
  logic [DATA_WIDTH-1:0]           sp_rd_data;
  logic                            array_clr;
  logic [ARRAY_DIM*DATA_WIDTH-1:0] a_data;
  logic [ARRAY_DIM*DATA_WIDTH-1:0] b_data;

  modport master (
    input  start, abort, base_addr, sp_rd_data,
    output busy, done, sp_rd_en, sp_rd_addr, array_clr, a_data, b_data
  );

  modport slave (
    output start, abort, base_addr, sp_rd_data,
    input  busy, done, sp_rd_en, sp_rd_addr, array_clr, a_data, b_data
  );
endinterface

// File: rtl/systolic_feed_ctrl_skew_lane_queue.sv
// Per-lane operand store: DEPTH-entry register file, indexed write and
// indexed combinational read that yields zero for out-of-range indices.
module skew_lane_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_idx < IDX_W'(DEPTH))) mem[wr_idx[SEL_W-1:0]] <= wr_data;
  end

  // Same-cycle write forwarding keeps a read of the entry being filled current.
  always_comb begin
    rd_data = '0;
    if (rd_idx < IDX_W'(DEPTH)) begin
      rd_data = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx[SEL_W-1:0]];
    end
  end
endmodule

// File: rtl/systolic_feed_ctrl.sv
// Operand sequencer for a systolic array: loads A rows and B columns from the
// scratchpad, replays them with a one-cycle-per-lane skew, drains, pulses done.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ARRAY_DIM    = DEF_ARRAY_DIM,
  parameter int K_DEPTH      = DEF_K_DEPTH,
  parameter int ADDR_WIDTH   = 5,
  parameter int DRAIN_CYCLES = 8
) (
  input logic                  clk,
  input logic                  reset,
  systolic_feed_ctrl_if.master bus
);
  localparam int NUM_READS  = 2 * ARRAY_DIM * K_DEPTH;
  localparam int LOAD_LEN   = NUM_READS + 1;
  localparam int STREAM_LEN = K_DEPTH + ARRAY_DIM - 1;
  localparam int MAX_LEN    = (LOAD_LEN > DRAIN_CYCLES) ? LOAD_LEN : DRAIN_CYCLES;
  localparam int CNT_W      = $clog2(MAX_LEN + 1);
  localparam int NUM_Q      = 2 * ARRAY_DIM;
  localparam int BUS_W      = ARRAY_DIM * DATA_WIDTH;

  typedef logic [CNT_W-1:0] cnt_t;

  state_t                state, state_next;
  cnt_t                  cnt, cnt_next;
  logic [ADDR_WIDTH-1:0] base, base_next;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + cnt_t'(1);
    base_next  = base;
    unique case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (bus.start) begin
          state_next = ST_LOAD;
          base_next  = bus.base_addr;
        end
      end
      ST_LOAD: if (cnt == cnt_t'(LOAD_LEN - 1)) begin
        state_next = ST_STREAM;
        cnt_next   = '0;
      end
      ST_STREAM: if (cnt == cnt_t'(STREAM_LEN - 1)) begin
        state_next = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
        cnt_next   = '0;
      end
      ST_DRAIN: if (cnt == cnt_t'(DRAIN_CYCLES - 1)) begin
        state_next = ST_DONE;
        cnt_next   = '0;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
    // abort overrides everything, including a start seen in IDLE.
    if (bus.abort) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      base  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      base  <= base_next;
    end
  end

  // Data read at LOAD count n arrives at count n+1 and belongs to stream n/K, element n%K.
  logic capture;
  cnt_t wr_pos, wr_stream, wr_elem;
  assign capture   = (state == ST_LOAD) && (cnt != '0) && !bus.abort;
  assign wr_pos    = cnt - cnt_t'(1);
  assign wr_stream = wr_pos / cnt_t'(K_DEPTH);
  assign wr_elem   = wr_pos % cnt_t'(K_DEPTH);

  cnt_t                  lane_idx [ARRAY_DIM];
  logic [DATA_WIDTH-1:0] q_rd     [NUM_Q];

  // Lane l replays element (step - l); K_DEPTH is an out-of-range index that reads zero.
  always_comb begin
    for (int l = 0; l < ARRAY_DIM; l++) begin
      lane_idx[l] = (cnt_next >= cnt_t'(l)) ? cnt_next - cnt_t'(l) : cnt_t'(K_DEPTH);
    end
  end

  for (genvar q = 0; q < NUM_Q; q++) begin : g_queue
    skew_lane_queue #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (K_DEPTH),
      .IDX_W     (CNT_W)
    ) u_queue (
      .clk    (clk),
      .wr_en  (capture && (wr_stream == cnt_t'(q))),
      .wr_idx (wr_elem),
      .wr_data(bus.sp_rd_data),
      .rd_idx (lane_idx[q % ARRAY_DIM]),
      .rd_data(q_rd[q])
    );
  end

  logic [BUS_W-1:0] a_next, b_next;

  always_comb begin
    a_next = '0;
    b_next = '0;
    if (state_next == ST_STREAM) begin
      for (int l = 0; l < ARRAY_DIM; l++) begin
        a_next[lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH] = q_rd[l];
        b_next[lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH] = q_rd[l + ARRAY_DIM];
      end
    end
  end

  logic read_next;
  assign read_next = (state_next == ST_LOAD) && (cnt_next < cnt_t'(NUM_READS));

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.sp_rd_en   <= 1'b0;
      bus.sp_rd_addr <= '0;
      bus.array_clr  <= 1'b0;
      bus.a_data     <= '0;
      bus.b_data     <= '0;
    end else begin
      bus.busy       <= (state_next != ST_IDLE);
      bus.done       <= (state_next == ST_DONE);
      bus.sp_rd_en   <= read_next;
      bus.sp_rd_addr <= read_next ? base_next + ADDR_WIDTH'(cnt_next) : '0;
      bus.array_clr  <= (state_next == ST_LOAD) && (cnt_next == '0);
      bus.a_data     <= a_next;
      bus.b_data     <= b_next;
    end
  end
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl with a registered scratchpad model
// and a behavioural 4x4 output-stationary PE array fed from the controller.
module tb_systolic_feed_ctrl;
  import systolic_pkg::*;

  localparam int DW = 32;
  localparam int D  = 4;
  localparam int K  = 4;
  localparam int AW = 5;
  localparam int NC = 60;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_feed_ctrl_if #(.DATA_WIDTH(DW), .ARRAY_DIM(D), .ADDR_WIDTH(AW)) bus ();

  systolic_feed_ctrl #(
    .DATA_WIDTH(DW), .ARRAY_DIM(D), .K_DEPTH(K), .ADDR_WIDTH(AW), .DRAIN_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  // Scratchpad: one-cycle read latency.
  logic [DW-1:0] mem [32];
  always @(posedge clk) if (bus.sp_rd_en) bus.sp_rd_data <= mem[bus.sp_rd_addr];

  // Output-stationary array: A moves right, B moves down, each PE accumulates a*b.
  logic [DW-1:0] pe_a [D][D];
  logic [DW-1:0] pe_b [D][D];
  logic [DW-1:0] pe_acc [D][D];
  logic [DW-1:0] pe_ain, pe_bin;
  always @(posedge clk) begin
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < D; c++) begin
        pe_ain = (c == 0) ? bus.a_data[lane_lsb(r, DW) +: DW] : pe_a[r][(c > 0) ? c - 1 : 0];
        pe_bin = (r == 0) ? bus.b_data[lane_lsb(c, DW) +: DW] : pe_b[(r > 0) ? r - 1 : 0][c];
        pe_a[r][c]   <= pe_ain;
        pe_b[r][c]   <= pe_bin;
        pe_acc[r][c] <= bus.array_clr ? '0 : pe_acc[r][c] + pe_ain * pe_bin;
      end
    end
  end

  int n_checks;
  int n_fail;

  logic          s_busy [NC+1];
  logic          s_done [NC+1];
  logic          s_en   [NC+1];
  logic          s_clr  [NC+1];
  logic [AW-1:0] s_addr [NC+1];
  logic [D*DW-1:0] s_a  [NC+1];
  logic [D*DW-1:0] s_b  [NC+1];
  logic [DW-1:0] s_acc [D][D];
  logic          r_busy, r_done, r_en, r_clr;
  logic [AW-1:0] r_addr;
  logic [D*DW-1:0] r_a, r_b;

  // Expected feed bus for STREAM step `step`; grp 0 = A lanes, 1 = B lanes.
  function automatic logic [D*DW-1:0] exp_feed_vec(input logic [AW-1:0] base, input int grp,
                                                   input int step);
    logic [D*DW-1:0] v;
    logic [AW-1:0]   addr;
    int              elem;
    v = '0;
    if (step >= 0 && step < K + D - 1) begin
      for (int l = 0; l < D; l++) begin
        elem = step - l;
        if (elem >= 0 && elem < K) begin
          addr = base + AW'((grp * D + l) * K + elem);
          v[lane_lsb(l, DW) +: DW] = mem[addr];
        end
      end
    end
    return v;
  endfunction

  // Start one run at the next edge and record outputs for cycles 1..NC (cycle c follows edge c-1).
  task automatic run_collect(input logic [AW-1:0] base, input int start_off, input int abort_cyc,
                             input int reset_cyc);
    @(negedge clk);
    bus.base_addr = base;
    bus.start     = 1'b1;
    bus.abort     = 1'b0;
    for (int c = 1; c <= NC; c++) begin
      @(negedge clk);
      s_busy[c] = bus.busy;
      s_done[c] = bus.done;
      s_en[c]   = bus.sp_rd_en;
      s_clr[c]  = bus.array_clr;
      s_addr[c] = bus.sp_rd_addr;
      s_a[c]    = bus.a_data;
      s_b[c]    = bus.b_data;
      if (c == 49) begin
        for (int r = 0; r < D; r++) for (int k = 0; k < D; k++) s_acc[r][k] = pe_acc[r][k];
      end
      if (c == 1) bus.base_addr = base + AW'(7);
      if (c >= start_off) bus.start = 1'b0;
      bus.abort = (c == abort_cyc);
      if (c == reset_cyc) begin
        reset = 1'b1;
        #1;
        r_busy = bus.busy; r_done = bus.done; r_en = bus.sp_rd_en; r_clr = bus.array_clr;
        r_addr = bus.sp_rd_addr; r_a = bus.a_data; r_b = bus.b_data;
        break;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_checks++; if (bus.sp_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b exp=0", bus.sp_rd_en); end
    n_checks++; if (bus.array_clr !== 1'b0) begin n_fail++; $display("FAIL reset_clr got=%b exp=0", bus.array_clr); end
    n_checks++; if (bus.sp_rd_addr !== '0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", bus.sp_rd_addr); end
    n_checks++; if (bus.a_data !== '0) begin n_fail++; $display("FAIL reset_a got=%h exp=0", bus.a_data); end
    n_checks++; if (bus.b_data !== '0) begin n_fail++; $display("FAIL reset_b got=%h exp=0", bus.b_data); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_basic();
    logic [D*DW-1:0] exp_v;
    for (int i = 0; i < 32; i++) mem[i] = DW'(i + 1);
    run_collect(AW'(0), 1, 0, 0);
    for (int c = 1; c <= NC; c++) begin
      n_checks++; if (s_en[c] !== (c <= 32)) begin n_fail++; $display("FAIL basic_rd_en c=%0d got=%b exp=%b", c, s_en[c], c <= 32); end
      if (c <= 32) begin
        n_checks++; if (s_addr[c] !== AW'(c - 1)) begin n_fail++; $display("FAIL basic_addr c=%0d got=%0d exp=%0d", c, s_addr[c], c - 1); end
      end
      n_checks++; if (s_clr[c] !== (c == 1)) begin n_fail++; $display("FAIL basic_clr c=%0d got=%b exp=%b", c, s_clr[c], c == 1); end
      n_checks++; if (s_done[c] !== (c == 49)) begin n_fail++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, s_done[c], c == 49); end
      n_checks++; if (s_busy[c] !== (c <= 49)) begin n_fail++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, s_busy[c], c <= 49); end
      exp_v = exp_feed_vec(AW'(0), 0, c - 34);
      n_checks++; if (s_a[c] !== exp_v) begin n_fail++; $display("FAIL basic_a c=%0d got=%h exp=%h", c, s_a[c], exp_v); end
      exp_v = exp_feed_vec(AW'(0), 1, c - 34);
      n_checks++; if (s_b[c] !== exp_v) begin n_fail++; $display("FAIL basic_b c=%0d got=%h exp=%h", c, s_b[c], exp_v); end
    end
    exp_v = {32'd13, 32'd10, 32'd7, 32'd4};
    n_checks++; if (s_a[37] !== exp_v) begin n_fail++; $display("FAIL basic_a_step3 got=%h exp=%h", s_a[37], exp_v); end
    exp_v = {96'd0, 32'd17};
    n_checks++; if (s_b[34] !== exp_v) begin n_fail++; $display("FAIL basic_b_step0 got=%h exp=%h", s_b[34], exp_v); end
    exp_v = {32'd32, 96'd0};
    n_checks++; if (s_b[40] !== exp_v) begin n_fail++; $display("FAIL basic_b_step6 got=%h exp=%h", s_b[40], exp_v); end
  endtask

  task automatic test_wrap();
    logic [D*DW-1:0] exp_v;
    run_collect(AW'(30), 1, 0, 0);
    for (int c = 1; c <= 32; c++) begin
      n_checks++; if (s_en[c] !== 1'b1 || s_addr[c] !== AW'(30 + c - 1)) begin
        n_fail++; $display("FAIL wrap_addr c=%0d got=%b/%0d exp=1/%0d", c, s_en[c], s_addr[c], (30 + c - 1) % 32); end
    end
    n_checks++; if (s_a[34][DW-1:0] !== 32'd31) begin n_fail++; $display("FAIL wrap_a0_step0 got=%0d exp=31", s_a[34][DW-1:0]); end
    for (int c = 34; c <= 40; c++) begin
      exp_v = exp_feed_vec(AW'(30), 0, c - 34);
      n_checks++; if (s_a[c] !== exp_v) begin n_fail++; $display("FAIL wrap_a c=%0d got=%h exp=%h", c, s_a[c], exp_v); end
      exp_v = exp_feed_vec(AW'(30), 1, c - 34);
      n_checks++; if (s_b[c] !== exp_v) begin n_fail++; $display("FAIL wrap_b c=%0d got=%h exp=%h", c, s_b[c], exp_v); end
    end
    n_checks++; if (s_done[49] !== 1'b1) begin n_fail++; $display("FAIL wrap_done got=%b exp=1", s_done[49]); end
  endtask

  task automatic test_start_held();
    int dones;
    run_collect(AW'(0), 50, 0, 0);
    dones = 0;
    for (int c = 1; c <= NC; c++) if (s_done[c] === 1'b1) dones++;
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL held_done_count got=%0d exp=1", dones); end
    n_checks++; if (s_done[49] !== 1'b1) begin n_fail++; $display("FAIL held_done_cycle got=%b exp=1", s_done[49]); end
    for (int c = 50; c <= NC; c++) begin
      n_checks++; if (s_busy[c] !== 1'b0) begin n_fail++; $display("FAIL held_restart c=%0d busy=%b exp=0", c, s_busy[c]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [D*DW-1:0] exp_v;
    run_collect(AW'(0), 1, 0, 0);
    for (int c = 1; c <= 52; c++) begin
      if (c <= 32) begin
        n_checks++; if (s_addr[c] !== AW'(c - 1)) begin n_fail++; $display("FAIL b2b_addr c=%0d got=%0d exp=%0d", c, s_addr[c], c - 1); end
      end
      n_checks++; if (s_done[c] !== (c == 49)) begin n_fail++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, s_done[c], c == 49); end
      exp_v = exp_feed_vec(AW'(0), 0, c - 34);
      n_checks++; if (s_a[c] !== exp_v) begin n_fail++; $display("FAIL b2b_a c=%0d got=%h exp=%h", c, s_a[c], exp_v); end
      exp_v = exp_feed_vec(AW'(0), 1, c - 34);
      n_checks++; if (s_b[c] !== exp_v) begin n_fail++; $display("FAIL b2b_b c=%0d got=%h exp=%h", c, s_b[c], exp_v); end
    end
  endtask

  task automatic test_abort();
    logic [D*DW-1:0] exp_v;
    run_collect(AW'(0), 1, 36, 0);
    exp_v = exp_feed_vec(AW'(0), 0, 2);
    n_checks++; if (s_a[36] !== exp_v) begin n_fail++; $display("FAIL abort_step2_a got=%h exp=%h", s_a[36], exp_v); end
    n_checks++; if (s_en[37] !== 1'b0) begin n_fail++; $display("FAIL abort_rd_en got=%b exp=0", s_en[37]); end
    n_checks++; if (s_a[37] !== '0 || s_b[37] !== '0) begin n_fail++; $display("FAIL abort_feeds got=%h/%h exp=0", s_a[37], s_b[37]); end
    for (int c = 37; c <= NC; c++) begin
      n_checks++; if (s_busy[c] !== 1'b0 || s_done[c] !== 1'b0) begin
        n_fail++; $display("FAIL abort_idle c=%0d busy=%b done=%b exp=0/0", c, s_busy[c], s_done[c]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [D*DW-1:0] exp_v;
    run_collect(AW'(0), 1, 0, 10);
    n_checks++; if (r_busy !== 1'b0 || r_done !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_done got=%b/%b exp=0/0", r_busy, r_done); end
    n_checks++; if (r_en !== 1'b0 || r_clr !== 1'b0) begin n_fail++; $display("FAIL rmid_en_clr got=%b/%b exp=0/0", r_en, r_clr); end
    n_checks++; if (r_addr !== '0) begin n_fail++; $display("FAIL rmid_addr got=%0d exp=0", r_addr); end
    n_checks++; if (r_a !== '0 || r_b !== '0) begin n_fail++; $display("FAIL rmid_feeds got=%h/%h exp=0", r_a, r_b); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_collect(AW'(0), 1, 0, 0);
    for (int c = 1; c <= 52; c++) begin
      n_checks++; if (s_done[c] !== (c == 49)) begin n_fail++; $display("FAIL rmid_run_done c=%0d got=%b exp=%b", c, s_done[c], c == 49); end
      exp_v = exp_feed_vec(AW'(0), 0, c - 34);
      n_checks++; if (s_a[c] !== exp_v) begin n_fail++; $display("FAIL rmid_run_a c=%0d got=%h exp=%h", c, s_a[c], exp_v); end
      exp_v = exp_feed_vec(AW'(0), 1, c - 34);
      n_checks++; if (s_b[c] !== exp_v) begin n_fail++; $display("FAIL rmid_run_b c=%0d got=%h exp=%h", c, s_b[c], exp_v); end
    end
  endtask

  // A = identity (rows at 0..15), B[k][c] = 100+10k+c (columns at 16..31), so C = B.
  task automatic test_pe_array();
    for (int r = 0; r < D; r++) for (int k = 0; k < K; k++) mem[r * K + k] = DW'(r == k);
    for (int c = 0; c < D; c++) for (int k = 0; k < K; k++) mem[16 + c * K + k] = DW'(100 + 10 * k + c);
    run_collect(AW'(0), 1, 0, 0);
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < D; c++) begin
        n_checks++; if (s_acc[r][c] !== DW'(100 + 10 * r + c)) begin
          n_fail++; $display("FAIL pe_product r=%0d c=%0d got=%0d exp=%0d", r, c, s_acc[r][c], 100 + 10 * r + c); end
      end
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.base_addr = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_start_held();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_pe_array();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_feed_ctrl.md
Name: systolic_feed_ctrl

Overview:
- Sequencer that loads A-row and B-column operand streams from the scratchpad into internal per-lane queues.
- Feeds them into the pearray4X4 edge inputs with diagonal skew: lane l is delayed l cycles.
- Then drains the array and signals completion.
- Replaces the ad-hoc queue/enable logic around the PE array with one reusable controller that has a start/done handshake.

Parameters:
- DATA_WIDTH, 32, operand width.
- ARRAY_DIM, 4, PE rows/cols; also the number of A lanes and of B lanes.
- K_DEPTH, 4, elements per lane stream.
- ADDR_WIDTH, 5, scratchpad address width.
- DRAIN_CYCLES, 8, zero-feed cycles after the last element so results settle.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE next cycle with no done.
- base_addr  in  ADDR_WIDTH  scratchpad base; captured when start is accepted.
- busy  out  1  high in LOAD/STREAM/DRAIN/DONE.
- done  out  1  one-cycle pulse; array results are valid this cycle.
- sp_rd_en  out  1  scratchpad read strobe.
- sp_rd_addr  out  ADDR_WIDTH  read address.
- sp_rd_data  in  DATA_WIDTH  read data, returned 1 cycle after sp_rd_en.
- array_clr  out  1  one-cycle pulse clearing PE accumulators.
- a_data  out  ARRAY_DIM*DATA_WIDTH  row feeds (in1..in4); lane l at [l*DATA_WIDTH +: DATA_WIDTH].
- b_data  out  ARRAY_DIM*DATA_WIDTH  column feeds (in5..in8); same lane packing.

Behaviour:
- Reset (async): state IDLE, counters cleared. busy, done, sp_rd_en, array_clr are 0. sp_rd_addr is 0. a_data and b_data are all zero. Queue contents are don't-care.
- All outputs are registered.
- IDLE: start=1 captures base_addr and enters LOAD next cycle. start is ignored in any other state.
- LOAD:
  - Lasts 2*ARRAY_DIM*K_DEPTH+1 cycles (33 by default).
  - In cycle n (n from 0 to 2*D*K-1) drive sp_rd_en=1 and sp_rd_addr=(base+n) mod 2^ADDR_WIDTH.
  - Data returned in cycle n+1 is written to stream s=n/K, element e=n%K. Streams s<D are A lane s; streams s>=D are B lane s-D.
  - The final cycle only captures data; sp_rd_en=0.
  - array_clr=1 in the first LOAD cycle only.
- STREAM:
  - Lasts K_DEPTH+ARRAY_DIM-1 cycles (7 by default); step index i counts 0..K+D-2.
  - During step i, lane l of both a_data and b_data equals element (i-l) when 0<=i-l<K, else 0.
  - A and B use identical skew.
- DRAIN: DRAIN_CYCLES cycles with a_data and b_data all zero.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE with busy=0. start in the DONE cycle is ignored.
- Default timeline, with start accepted at edge 0:
  - LOAD cycles 1..33.
  - STREAM cycles 34..40.
  - DRAIN cycles 41..48.
  - done in cycle 49.
- Address wrap: base+n wraps modulo 2^ADDR_WIDTH with no error.
- abort:
  - Takes effect from any non-IDLE state: next cycle is IDLE.
  - Feeds are zeroed and sp_rd_en=0. No done pulse.
  - A read already in flight is discarded.
  - abort wins over start when both are asserted in IDLE.
- Reset mid-operation: immediate return to the reset values above; no done.
- DRAIN_CYCLES=0 goes straight from STREAM to DONE.

Decomposition:
- Shared package systolic_pkg holds:
  - the state encoding (IDLE, LOAD, STREAM, DRAIN, DONE);
  - the lane-packing helper macro/function for lane l;
  - the default ARRAY_DIM and K_DEPTH constants.
- One sub-module, skew_lane_queue: a K_DEPTH-entry register file per lane with write-by-index and read-by-index.
  - Read returns zero when the index is out of range.
  - It is instantiated 2*ARRAY_DIM times.
- The FSM, counters and address generator stay in the top module.

Test Plan:
- Scratchpad word a = a+1, base 0, single start. Expected:
  - sp_rd_addr runs 0..31 in cycles 1..32.
  - array_clr high only in cycle 1.
  - In STREAM step 3, a_data lanes are {4,7,10,13}.
  - In step 0, b_data lane0=17 and the other lanes are 0.
  - In step 6, b_data lane3=32 and the other lanes are 0.
  - done in cycle 49.
- base_addr=30: read addresses are 30,31,0,1,...; a_data lane0 step 0 holds word 30.
- start held high through the whole run and in the DONE cycle: exactly one done and no restart. Re-asserting start after IDLE gives an identical second run.
- abort asserted in STREAM step 2: next cycle IDLE, busy=0, feeds zero, no done.
- reset pulse during LOAD cycle 10: all outputs go to their reset values immediately. A subsequent start gives a full correct run.
- Full-run check with the outputs connected to pearray4X4:
  - With A = identity and B = word values, out1..out4 match the reference matrix product in the done cycle.
